idct_macu: RTL and testbench
============================

// Module: idct_macu
// PURPOSE
//   Decoder-side counterpart of the fdct_zigzag DCT multiply-accumulate unit:
//   one-dimensional 8-point inverse DCT on a single time-shared multiplier.
//   Takes 8 signed coefficients X[0..7] in natural order and returns 8 spatial
//   samples x[0..7]. Two instances (row pass, column pass) form the decoder's
//   2-D IDCT, fed by the de-zigzag buffer.
// PARAMETERS
//   COEF_W  12  signed input coefficient width
//   ROM_W   12  signed cosine weight width, Q1.(FRAC)
//   FRAC    11  fractional bits of the weights (scale 2^11 = 2048)
//   OUT_W   9   signed output sample width (saturating)
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        coefficient present on in_data
//   in_ready   out  1        unit accepts a coefficient (high only in LOAD)
//   in_data    in   COEF_W   coefficient X[k], k = 0..7 in order
//   out_valid  out  1        sample present on out_data
//   out_ready  in   1        downstream accepts the sample
//   out_data   out  OUT_W    spatial sample x[n]
//   out_last   out  1        high with x[7]
// BEHAVIOUR
//   - Reset: state=LOAD, k=n=0, acc=0, in_ready=0 during reset and 1 from the
//     first cycle after it; out_valid=0, out_data=0, out_last=0. A reset in
//     any state drops any partial row and any pending output.
//   - Handshake: a transfer happens on a clock edge where valid&&ready. Once
//     out_valid rises, it stays high and out_data/out_last stay stable until
//     accepted.
//   - Weight ROM: w[n][k] = round(2048 * c(k)/2 * cos((2n+1)k*pi/16)),
//     c(0)=1/sqrt2, else 1. Examples: w[*][0]=724, w[0][1]=1004,
//     w[7][1]=-1004.
//   - FSM LOAD: store each accepted coefficient in creg[k], k++. The edge that
//     accepts k=7 moves to MAC with n=0 and in_ready=0.
//   - FSM MAC: issue creg[k]*w[n][k] for k=0..7 on 8 consecutive cycles. The
//     product is registered (1 stage) and summed into a 27-bit signed acc,
//     which is cleared on the first issue. Then RND: y = (acc + 1024) >>> 11,
//     i.e. round half toward +inf, saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//     y is loaded into out_data, and state goes to OUT.
//   - Latency: out_valid is high exactly 10 cycles after the edge that accepts
//     X[7]. The same holds after each output handshake for the next sample.
//   - FSM OUT: hold out_valid. On the accepting edge: if n==7, go to LOAD with
//     in_ready=1 on the next cycle and k=0. Otherwise n++ and go to MAC.
//   - in_valid outside LOAD is ignored, and no coefficients are buffered.
//     out_ready outside OUT has no effect.
//   - out_last = out_valid && (n==7).
//   - Throughput: one row per 8 + 8*(10+1) cycles minimum (out_ready held
//     high).
// TESTING
//   1. DC only: X=[256,0,...,0] -> eight samples of 91, out_last only on the
//      8th; first out_valid 10 cycles after X[7].
//   2. Negative DC: X=[-256,0,...] -> eight samples of -90 (check the
//      rounding direction).
//   3. Single AC: X=[0,256,0,...] -> x[0]=126, x[7]=-125; the rest match the
//      double-precision reference model after ROM rounding.
//   4. Saturation: X=[2047,0,...] -> all 255; X=[-2048,0,...] -> all -256.
//   5. Backpressure: out_ready low 20 cycles on x[3] -> out_valid and
//      out_data stable; in_valid pulses meanwhile are not accepted.
//   6. Reset mid-row after 5 coefficients, and again mid-MAC -> next cycle
//      out_valid=0, in_ready=1; a fresh row of 8 then gives correct results.

Source files
------------

// File: rtl/idct_macu.sv
// ---------------------------------------------------------------------------
// idct_macu
//   One-dimensional 8-point inverse DCT on a single time-shared multiplier.
//   Eight signed coefficients X[0..7] are loaded in natural order, then
//   each spatial sample x[n] is formed as sum_k X[k]*w[n][k]. The sum is
//   rounded half toward +inf, saturated to OUT_W bits and handed out one
//   sample at a time with a valid/ready handshake. The next sample is only
//   computed after the current one has been accepted.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   coefficient present on in_data
//   in_ready   unit accepts a coefficient (LOAD state only)
//   in_data    coefficient X[k], k = 0..7 in order
//   out_valid  sample present on out_data
//   out_ready  downstream accepts the sample
//   out_data   spatial sample x[n], saturated
//   out_last   high together with x[7]
// ---------------------------------------------------------------------------
module idct_macu #(
    parameter int COEF_W = 12,
    parameter int ROM_W  = 12,
    parameter int FRAC   = 11,
    parameter int OUT_W  = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_last
);

    localparam int PROD_W = COEF_W + ROM_W;
    localparam int ACC_W  = 27;
    localparam int HALF   = 1 << (FRAC - 1);
    localparam int Y_MAX  = (1 << (OUT_W - 1)) - 1;
    localparam int Y_MIN  = -(1 << (OUT_W - 1));

    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    // Cosine weight w[n][k] = round(2048 * c(k)/2 * cos((2n+1)k*pi/16)).
    // The angle index m = (2n+1)k mod 32 is folded onto the first quadrant:
    // cos is even about m=16 (m -> 32-m) and odd about m=8 (m -> 16-m).
    function automatic logic signed [ROM_W-1:0] weight(input logic [2:0] wn,
                                                       input logic [2:0] wk);
        logic [6:0] angle;
        logic [4:0] m;
        logic [4:0] f;
        logic [4:0] sel;
        logic       neg;
        int         mag;
        angle = {3'b000, wn, 1'b1} * {4'b0000, wk};
        m     = angle[4:0];
        f     = (m > 5'd16) ? 5'd0 - m : m;
        neg   = (f > 5'd8);
        sel   = neg ? 5'd16 - f : f;
        case (sel)
            5'd0:    mag = 1024;
            5'd1:    mag = 1004;
            5'd2:    mag = 946;
            5'd3:    mag = 851;
            5'd4:    mag = 724;
            5'd5:    mag = 569;
            5'd6:    mag = 392;
            5'd7:    mag = 200;
            default: mag = 0;
        endcase
        // k = 0 carries the extra 1/sqrt2 normalisation: 1024/sqrt2 = 724
        if (wk == 3'd0)
            weight = ROM_W'(724);
        else
            weight = ROM_W'(neg ? -mag : mag);
    endfunction

    // (acc + 0.5) >>> FRAC rounds half toward +inf; clamp to the OUT_W range.
    function automatic logic signed [OUT_W-1:0] rnd_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = (a + ACC_W'(HALF)) >>> FRAC;
        if (s > ACC_W'(Y_MAX))
            rnd_sat = OUT_W'(Y_MAX);
        else if (s < ACC_W'(Y_MIN))
            rnd_sat = OUT_W'(Y_MIN);
        else
            rnd_sat = OUT_W'(s);
    endfunction

    logic [1:0]               state;
    logic [3:0]               k;      // coefficient index in LOAD, MAC step 0..9 in MAC
    logic [2:0]               n;      // output sample index
    logic                     issue;

    logic signed [COEF_W-1:0] creg [0:7];
    logic signed [PROD_W-1:0] prod_p1;
    logic                     vld_p1;
    logic                     first_p1;
    logic signed [ACC_W-1:0]  acc_p2;
    logic signed [OUT_W-1:0]  y_p3;
    logic                     vld_p3;

    assign in_ready  = (state == LOAD) && !rst;
    assign issue     = (state == MAC) && (k < 4'd8);
    assign out_valid = vld_p3;
    assign out_data  = y_p3;
    assign out_last  = vld_p3 && (n == 3'd7);

    // Coefficient store and multiplier: plain data, no reset needed.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready)
            creg[k[2:0]] <= in_data;
        // stage p0 -> p1: one product per MAC step
        if (issue)
            prod_p1 <= PROD_W'(creg[k[2:0]]) * PROD_W'(weight(n, k[2:0]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            k        <= 4'd0;
            n        <= 3'd0;
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            acc_p2   <= '0;
            y_p3     <= '0;
            vld_p3   <= 1'b0;
        end else begin
            vld_p1   <= issue;
            first_p1 <= issue && (k == 4'd0);

            // stage p1 -> p2: accumulate, restarting on the first product
            if (vld_p1)
                acc_p2 <= first_p1 ? ACC_W'(prod_p1) : acc_p2 + ACC_W'(prod_p1);

            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (k == 4'd7) begin
                            state <= MAC;
                            k     <= 4'd0;
                        end else begin
                            k <= k + 4'd1;
                        end
                    end
                end
                MAC: begin
                    // steps 0..7 issue, step 8 folds in the last product,
                    // step 9 rounds the finished sum
                    // stage p2 -> p3: round, saturate, present
                    if (k == 4'd9) begin
                        y_p3   <= rnd_sat(acc_p2);
                        vld_p3 <= 1'b1;
                        state  <= OUT;
                        k      <= 4'd0;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        vld_p3 <= 1'b0;
                        k      <= 4'd0;
                        if (n == 3'd7) begin
                            n     <= 3'd0;
                            state <= LOAD;
                        end else begin
                            n     <= n + 3'd1;
                            state <= MAC;
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                    k     <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idct_macu.sv
// ---------------------------------------------------------------------------
// tb_idct_macu
//   Directed bench for idct_macu: DC, negative DC, single AC, saturation,
//   a mixed all-equal row, backpressure and resets mid-row / mid-MAC.
//   Expected samples are hand-computed from the rounded cosine weights.
// ---------------------------------------------------------------------------
module tb_idct_macu;

    localparam int COEF_W = 12;
    localparam int OUT_W  = 9;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [COEF_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_last;

    int n_chk  = 0;
    int n_fail = 0;

    logic signed [COEF_W-1:0] row [8];
    int                       exp_y [8];

    idct_macu #(
        .COEF_W(COEF_W),
        .ROM_W (12),
        .FRAC  (11),
        .OUT_W (OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int pos, input int val, input int fill);
        for (int i = 0; i < 8; i++)
            row[i] = (i == pos) ? COEF_W'(val) : COEF_W'(fill);
    endtask

    // push the first cnt coefficients of row
    task automatic send_row(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int w;
            w        = 0;
            in_valid = 1'b1;
            in_data  = row[i];
            while (!in_ready && w < 200) begin
                step();
                w++;
            end
            if (!in_ready)
                check_val("send_timeout", 0, 1);
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // collect 8 samples; sample hold_idx is held off for 20 cycles
    task automatic recv_row(input string tag, input int hold_idx);
        for (int i = 0; i < 8; i++) begin
            int                      lat;
            int                      bad;
            logic signed [OUT_W-1:0] held;
            logic                    held_last;
            lat       = 0;
            out_ready = 1'b1;
            while (!out_valid && lat < 40) begin
                step();
                lat++;
            end
            check_val($sformatf("%s_lat%0d", tag, i), lat, 10);
            check_val($sformatf("%s_x%0d", tag, i), out_data, exp_y[i]);
            check_val($sformatf("%s_last%0d", tag, i), int'(out_last), (i == 7) ? 1 : 0);
            if (i == hold_idx) begin
                out_ready = 1'b0;
                held      = out_data;
                held_last = out_last;
                bad       = 0;
                for (int j = 0; j < 20; j++) begin
                    in_valid = j[0];
                    in_data  = COEF_W'(100);
                    step();
                    if (out_valid !== 1'b1 || out_data !== held ||
                        out_last !== held_last || in_ready !== 1'b0)
                        bad++;
                end
                in_valid = 1'b0;
                in_data  = '0;
                check_val($sformatf("%s_hold_stable", tag), bad, 0);
                out_ready = 1'b1;
            end
            step();
        end
        check_val($sformatf("%s_ready_after", tag), int'(in_ready), 1);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_val($sformatf("%s_out_valid", tag), int'(out_valid), 0);
        check_val($sformatf("%s_in_ready", tag), int'(in_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        check_val("rst_in_ready", int'(in_ready), 0);
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_last", int'(out_last), 0);
        rst = 1'b0;
        #1;
        check_val("post_rst_in_ready", int'(in_ready), 1);

        // DC only
        set_row(0, 256, 0);
        exp_y = '{91, 91, 91, 91, 91, 91, 91, 91};
        send_row(8);
        recv_row("dc", -1);

        // negative DC: -90.0 exactly, rounding must not pull it to -91
        set_row(0, -256, 0);
        exp_y = '{-90, -90, -90, -90, -90, -90, -90, -90};
        send_row(8);
        recv_row("ndc", -1);

        // single AC term: x[n] = floor(w[n][1]/8 + 0.5)
        set_row(1, 256, 0);
        exp_y = '{126, 106, 71, 25, -25, -71, -106, -125};
        send_row(8);
        recv_row("ac", -1);

        // saturation both ways
        set_row(0, 2047, 0);
        exp_y = '{255, 255, 255, 255, 255, 255, 255, 255};
        send_row(8);
        recv_row("satp", -1);

        set_row(0, -2048, 0);
        exp_y = '{-256, -256, -256, -256, -256, -256, -256, -256};
        send_row(8);
        recv_row("satn", -1);

        // all coefficients 16: every weight column contributes
        set_row(0, 16, 16);
        exp_y = '{42, -12, 9, -3, 5, 0, 3, 1};
        send_row(8);
        recv_row("mix", -1);

        // backpressure on x[3], with in_valid pulses that must be ignored
        set_row(1, 256, 0);
        exp_y = '{126, 106, 71, 25, -25, -71, -106, -125};
        send_row(8);
        recv_row("bp", 3);

        // row after backpressure must be unaffected by the ignored pulses
        set_row(0, 256, 0);
        exp_y = '{91, 91, 91, 91, 91, 91, 91, 91};
        send_row(8);
        recv_row("bp_next", -1);

        // reset after 5 coefficients, then a fresh DC row
        set_row(0, -2048, 0);
        row[4] = COEF_W'(2047);
        send_row(5);
        pulse_reset("rst_load");
        set_row(0, 256, 0);
        exp_y = '{91, 91, 91, 91, 91, 91, 91, 91};
        send_row(8);
        recv_row("rst_load_row", -1);

        // reset in the middle of a MAC sequence, then a fresh mixed row
        set_row(0, 2047, 0);
        send_row(8);
        for (int i = 0; i < 4; i++)
            step();
        pulse_reset("rst_mac");
        set_row(0, 16, 16);
        exp_y = '{42, -12, 9, -3, 5, 0, 3, 1};
        send_row(8);
        recv_row("rst_mac_row", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
